trng_key_reader: RTL

Consumer-side controller for the TRNG key handshake (`key_ready` / `out_key` / `ack_read` / `trng_intr`). It enables the TRNG, captures each delivered key, acknowledges it, and screens out all-zero and repeated keys. Accepted keys are buffered in a small FIFO for a downstream valid/ready reader, such as a bus register file or a crypto core. The block also supervises the source for total-failure interrupts, delivery timeouts and stuck output, and parks in a fault state until software clears it.

---
 rtl/trng_key_reader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/trng_key_reader.sv
// TRNG consumer: enables the source, acknowledges and screens each key,
// buffers accepted keys in a FIFO and parks in FAULT on source failures.
module trng_key_reader #(
    parameter int N_BITS_KEY     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int REJECT_LIMIT   = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            clear_err_i,
    input  logic                            trng_key_ready_i,
    input  logic [N_BITS_KEY-1:0]           trng_key_i,
    input  logic                            trng_intr_i,
    output logic                            trng_enable_o,
    output logic                            trng_ack_read_o,
    output logic                            rd_valid_o,
    output logic [N_BITS_KEY-1:0]           rd_data_o,
    input  logic                            rd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
    output logic [1:0]                      err_code_o,
    output logic                            fault_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(REJECT_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_KEY,
        ACK,
        RELEASE,
        FAULT
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tmo_q;
    logic [RW-1:0]         rej_q, rej_d;
    logic [1:0]            err_q, err_d;
    logic [N_BITS_KEY-1:0] cap_q, last_q;
    logic [N_BITS_KEY-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [LW-1:0]         lvl_q;
    logic                  full, accept, push, pop, tmo_hit, clr;

    assign full    = (lvl_q == LW'(FIFO_DEPTH));
    assign accept  = (cap_q != '0) && (cap_q != last_q);
    assign push    = (state_q == ACK) && accept;
    assign pop     = rd_ready_i && (lvl_q != '0);
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rej_d   = rej_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !full) state_d = WAIT_KEY;
            end
            WAIT_KEY: begin
                if (trng_key_ready_i) begin
                    state_d = ACK;
                end else if (tmo_hit) begin
                    state_d = FAULT;
                    err_d   = 2'b10;
                end else if (!start_i) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = RELEASE;
                if (accept) begin
                    rej_d = '0;
                end else begin
                    rej_d = rej_q + RW'(1);
                    if (rej_d == RW'(REJECT_LIMIT)) begin
                        state_d = FAULT;
                        err_d   = 2'b11;
                    end
                end
            end
            RELEASE: begin
                // a ready level left over from the last key must drop first
                if (!trng_key_ready_i)
                    state_d = (start_i && !full) ? WAIT_KEY : IDLE;
            end
            FAULT: begin
                if (clear_err_i) begin
                    state_d = IDLE;
                    err_d   = 2'b00;
                    rej_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // interrupt outranks every other cause, including a clear
        if (trng_intr_i && (state_q != FAULT || clear_err_i)) begin
            state_d = FAULT;
            err_d   = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            rej_q   <= '0;
            err_q   <= '0;
            cap_q   <= '0;
            last_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rej_q   <= rej_d;
            tmo_q   <= (state_q == WAIT_KEY) ? tmo_q + TW'(1) : '0;
            if (state_q == WAIT_KEY && trng_key_ready_i) cap_q <= trng_key_i;
            if (clr)       last_q <= '0;
            else if (push) last_q <= cap_q;
            if (push) begin
                mem_q[wr_q] <= cap_q;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            if (push && !pop)      lvl_q <= lvl_q + LW'(1);
            else if (!push && pop) lvl_q <= lvl_q - LW'(1);
        end
    end

    assign trng_enable_o   = (state_q == WAIT_KEY) || (state_q == ACK) ||
                             (state_q == RELEASE);
    assign trng_ack_read_o = (state_q == ACK);
    assign rd_valid_o      = (lvl_q != '0);
    assign rd_data_o       = mem_q[rd_q];
    assign fifo_level_o    = lvl_q;
    assign err_code_o      = err_q;
    assign fault_o         = (state_q == FAULT);

endmodule
